// File: rtl/Public_Info.sv
// Shared instruction-bundle definitions used by the issue stage and its scoreboard.
package Public_Info;

    localparam int REG_NUM = 32;

    localparam logic [2:0] INST_TYPE_NONE   = 3'd0;
    localparam logic [2:0] INST_TYPE_ALU    = 3'd1;
    localparam logic [2:0] INST_TYPE_LOAD   = 3'd2;
    localparam logic [2:0] INST_TYPE_STORE  = 3'd3;
    localparam logic [2:0] INST_TYPE_BRANCH = 3'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [2:0]  inst_type;
        logic        rf_we;
        logic [4:0]  rf_rd;
        logic [4:0]  rf_raddr1;
        logic [4:0]  rf_raddr2;
        logic [2:0]  br_type;
        logic [2:0]  ldst_type;
    } PC_set;

    // Recognisable poison value presented on the EX ports straight after reset.
    localparam PC_set error_set = '{
        pc:        32'hFFFF_FFFC,
        inst_type: INST_TYPE_NONE,
        rf_we:     1'b0,
        rf_rd:     5'd0,
        rf_raddr1: 5'd0,
        rf_raddr2: 5'd0,
        br_type:   3'd0,
        ldst_type: 3'd0
    };

    function automatic logic is_busy_load(input PC_set s);
        return (s.inst_type == INST_TYPE_LOAD) && s.rf_we && (s.rf_rd != 5'd0);
    endfunction

endpackage

// File: rtl/issue_scoreboard.sv
// Per-register load-use countdown; a register stays busy while its count is nonzero.
module issue_scoreboard
    import Public_Info::*;
#(
    parameter int LD_LAT = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            flush,
    input  logic [3:0][4:0] raddr,
    output logic [3:0]      busy,
    input  logic            set1_en,
    input  logic [4:0]      set1_addr,
    input  logic            set2_en,
    input  logic [4:0]      set2_addr
);

    localparam logic [1:0] LAT = 2'(LD_LAT);

    logic [1:0] count [REG_NUM];

    // A fresh load on this edge wins over the decrement of the same entry.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int r = 0; r < REG_NUM; r++) begin
                count[r] <= 2'd0;
            end
        end else if (!stall) begin
            for (int r = 0; r < REG_NUM; r++) begin
                if ((set1_en && set1_addr == 5'(r)) || (set2_en && set2_addr == 5'(r))) begin
                    count[r] <= LAT;
                end else if (count[r] != 2'd0) begin
                    count[r] <= count[r] - 2'd1;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            busy[i] = (raddr[i] != 5'd0) && (count[raddr[i]] != 2'd0);
        end
    end

endmodule

// File: rtl/issue_ctrl.sv
// Dual-issue pairing stage: picks zero, one or two instructions from the buffer head each cycle.
module issue_ctrl
    import Public_Info::*;
#(
    parameter int LD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  PC_set       i_PC_set1,
    input  PC_set       i_PC_set2,
    input  logic [1:0]  i_is_valid,
    input  logic        flush_BR,
    input  logic        stall_DCache,
    output logic [1:0]  o_usingNUM,
    output PC_set       o_EX_set1,
    output PC_set       o_EX_set2,
    output logic [1:0]  o_EX_valid,
    output logic [31:0] o_dual_cnt
);

    logic [3:0][4:0] src_addr;
    logic [3:0]      src_busy;
    logic            a_issue;
    logic            b_issue;
    logic            raw_ab;
    logic            both_mem;

    assign src_addr = {i_PC_set2.rf_raddr2, i_PC_set2.rf_raddr1,
                       i_PC_set1.rf_raddr2, i_PC_set1.rf_raddr1};

    issue_scoreboard #(.LD_LAT(LD_LAT)) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall_DCache),
        .flush     (flush_BR),
        .raddr     (src_addr),
        .busy      (src_busy),
        .set1_en   (a_issue && is_busy_load(i_PC_set1)),
        .set1_addr (i_PC_set1.rf_rd),
        .set2_en   (b_issue && is_busy_load(i_PC_set2)),
        .set2_addr (i_PC_set2.rf_rd)
    );

    // B only pairs behind A when it has no RAW on A, A is not a branch, and the single LSU is free.
    always_comb begin
        raw_ab   = i_PC_set1.rf_we && (i_PC_set1.rf_rd != 5'd0) &&
                   ((i_PC_set2.rf_raddr1 == i_PC_set1.rf_rd) ||
                    (i_PC_set2.rf_raddr2 == i_PC_set1.rf_rd));
        both_mem = (i_PC_set1.ldst_type != 3'd0) && (i_PC_set2.ldst_type != 3'd0);
        a_issue  = i_is_valid[1] && !rst && !stall_DCache && !flush_BR &&
                   !src_busy[0] && !src_busy[1];
        b_issue  = a_issue && i_is_valid[0] && !src_busy[2] && !src_busy[3] &&
                   !raw_ab && (i_PC_set1.br_type == 3'd0) && !both_mem;
        o_usingNUM = b_issue ? 2'b10 : (a_issue ? 2'b01 : 2'b00);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_EX_set1  <= error_set;
            o_EX_set2  <= error_set;
            o_EX_valid <= 2'b00;
            o_dual_cnt <= 32'd0;
        end else if (flush_BR) begin
            o_EX_valid <= 2'b00;
        end else if (!stall_DCache) begin
            o_EX_set1  <= i_PC_set1;
            o_EX_set2  <= i_PC_set2;
            o_EX_valid <= {a_issue, b_issue};
            if (b_issue) begin
                o_dual_cnt <= o_dual_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_issue_ctrl.sv
// Self-checking bench for issue_ctrl: directed scenarios with literal expectations plus randomized traffic vs. a ready-time model.
module tb_issue_ctrl;
    import Public_Info::*;

    localparam int LAT = 1;

    logic        clk;
    logic        rst;
    PC_set       a_in;
    PC_set       b_in;
    logic [1:0]  valid_in;
    logic        flush_in;
    logic        stall_in;
    logic [1:0]  o_usingNUM;
    PC_set       o_EX_set1;
    PC_set       o_EX_set2;
    logic [1:0]  o_EX_valid;
    logic [31:0] o_dual_cnt;

    int checks = 0;
    int errors = 0;

    // Model state: a register is busy until the non-stall edge counter reaches its ready time.
    int          ready [REG_NUM];
    int          ns_edges = 0;
    logic [1:0]  exp_valid;
    PC_set       exp_set1;
    PC_set       exp_set2;
    logic [31:0] exp_dual;
    logic        exp_sets_known = 1'b0;
    logic        run_compare = 1'b0;

    issue_ctrl #(.LD_LAT(LAT)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_PC_set1    (a_in),
        .i_PC_set2    (b_in),
        .i_is_valid   (valid_in),
        .flush_BR     (flush_in),
        .stall_DCache (stall_in),
        .o_usingNUM   (o_usingNUM),
        .o_EX_set1    (o_EX_set1),
        .o_EX_set2    (o_EX_set2),
        .o_EX_valid   (o_EX_valid),
        .o_dual_cnt   (o_dual_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic m_busy(input logic [4:0] r);
        return (r != 5'd0) && (ready[r] > ns_edges);
    endfunction

    // Returns {A issues, B issues} from the pairing rules applied to the current inputs.
    function automatic logic [1:0] m_issue();
        logic a_ok;
        logic b_ok;
        a_ok = valid_in[1] && !rst && !stall_in && !flush_in &&
               !m_busy(a_in.rf_raddr1) && !m_busy(a_in.rf_raddr2);
        b_ok = a_ok && valid_in[0] &&
               !m_busy(b_in.rf_raddr1) && !m_busy(b_in.rf_raddr2) &&
               !(a_in.rf_we && a_in.rf_rd != 5'd0 &&
                 (b_in.rf_raddr1 == a_in.rf_rd || b_in.rf_raddr2 == a_in.rf_rd)) &&
               (a_in.br_type == 3'd0) &&
               !(a_in.ldst_type != 3'd0 && b_in.ldst_type != 3'd0);
        return {a_ok, b_ok};
    endfunction

    function automatic logic [1:0] m_using();
        logic [1:0] iss;
        iss = m_issue();
        return iss[0] ? 2'b10 : (iss[1] ? 2'b01 : 2'b00);
    endfunction

    function automatic logic m_is_load(input PC_set s);
        return s.inst_type == INST_TYPE_LOAD && s.rf_we && s.rf_rd != 5'd0;
    endfunction

    task automatic modelEdge();
        logic [1:0] iss;
        iss = m_issue();
        if (rst) begin
            for (int r = 0; r < REG_NUM; r++) ready[r] = 0;
            exp_valid = 2'b00;
            exp_set1 = error_set;
            exp_set2 = error_set;
            exp_dual = 32'd0;
            exp_sets_known = 1'b1;
        end else if (flush_in) begin
            for (int r = 0; r < REG_NUM; r++) ready[r] = 0;
            exp_valid = 2'b00;
            exp_sets_known = 1'b0;
        end else if (!stall_in) begin
            ns_edges++;
            exp_set1 = a_in;
            exp_set2 = b_in;
            exp_valid = iss;
            exp_sets_known = 1'b1;
            if (iss == 2'b11) exp_dual = exp_dual + 32'd1;
            if (iss[1] && m_is_load(a_in)) ready[a_in.rf_rd] = ns_edges + LAT;
            if (iss[0] && m_is_load(b_in)) ready[b_in.rf_rd] = ns_edges + LAT;
        end
    endtask

    always @(negedge clk) begin
        if (run_compare) begin
            checkOutput("usingNUM", 64'(o_usingNUM), 64'(m_using()));
            checkOutput("EX_valid", 64'(o_EX_valid), 64'(exp_valid));
            checkOutput("dual_cnt", 64'(o_dual_cnt), 64'(exp_dual));
            if (exp_sets_known) begin
                checkOutput("EX_set1", 64'(o_EX_set1), 64'(exp_set1));
                checkOutput("EX_set2", 64'(o_EX_set2), 64'(exp_set2));
            end
        end
    end

    // kind: 0 alu, 1 load, 2 store, 3 branch
    function automatic PC_set mk(input int kind, input int rd, input int r1, input int r2);
        PC_set s;
        s = '0;
        s.pc = $urandom;
        s.rf_raddr1 = 5'(r1);
        s.rf_raddr2 = 5'(r2);
        case (kind)
            0: begin s.inst_type = INST_TYPE_ALU;    s.rf_we = 1'b1; s.rf_rd = 5'(rd); end
            1: begin s.inst_type = INST_TYPE_LOAD;   s.rf_we = 1'b1; s.rf_rd = 5'(rd); s.ldst_type = 3'd1; end
            2: begin s.inst_type = INST_TYPE_STORE;  s.ldst_type = 3'd5; end
            default: begin s.inst_type = INST_TYPE_BRANCH; s.br_type = 3'd1; end
        endcase
        return s;
    endfunction

    // Drives one cycle; optionally pins o_usingNUM to a hand-computed literal before the edge.
    task automatic applyStimulus(input PC_set a, input PC_set b, input logic [1:0] v,
                                 input logic st, input logic fl, input logic rs,
                                 input logic chk, input logic [1:0] exp_using, input string name);
        a_in = a;
        b_in = b;
        valid_in = v;
        stall_in = st;
        flush_in = fl;
        rst = rs;
        @(negedge clk);
        #1;
        if (chk) checkOutput(name, 64'(o_usingNUM), 64'(exp_using));
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    PC_set nop;

    initial begin
        nop = mk(0, 0, 0, 0);
        applyStimulus(nop, nop, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, "");
        run_compare = 1'b1;
        applyStimulus(nop, nop, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, "using_in_reset");
        checkOutput("reset_valid", 64'(o_EX_valid), 64'd0);
        checkOutput("reset_dual", 64'(o_dual_cnt), 64'd0);
        checkOutput("reset_set1", 64'(o_EX_set1), 64'(error_set));

        applyStimulus(mk(0, 3, 1, 2), mk(0, 4, 1, 2), 2'b11, 0, 0, 0, 1, 2'b10, "pair_indep");
        checkOutput("pair_valid", 64'(o_EX_valid), 64'h3);
        checkOutput("pair_dual", 64'(o_dual_cnt), 64'd1);

        applyStimulus(mk(0, 5, 1, 2), mk(0, 6, 5, 1), 2'b11, 0, 0, 0, 1, 2'b01, "raw_block");
        applyStimulus(mk(0, 6, 5, 1), nop, 2'b10, 0, 0, 0, 1, 2'b01, "raw_follow");
        checkOutput("raw_dual", 64'(o_dual_cnt), 64'd1);

        applyStimulus(mk(1, 7, 1, 0), nop, 2'b10, 0, 0, 0, 1, 2'b01, "ld_issue");
        applyStimulus(mk(0, 8, 7, 0), nop, 2'b10, 0, 0, 0, 1, 2'b00, "ld_use_bubble");
        applyStimulus(mk(0, 8, 7, 0), nop, 2'b10, 0, 0, 0, 1, 2'b01, "ld_use_after");

        applyStimulus(mk(3, 0, 1, 2), mk(0, 9, 1, 2), 2'b11, 0, 0, 0, 1, 2'b01, "branch_solo");
        applyStimulus(mk(1, 11, 1, 0), mk(2, 0, 2, 3), 2'b11, 0, 0, 0, 1, 2'b01, "one_lsu");

        for (int i = 0; i < 3; i++)
            applyStimulus(mk(0, 12, 1, 2), mk(0, 13, 1, 2), 2'b11, 1, 0, 0, 1, 2'b00, "stall_using");
        checkOutput("stall_hold_valid", 64'(o_EX_valid), 64'h2);
        applyStimulus(mk(0, 12, 11, 0), nop, 2'b10, 0, 0, 0, 1, 2'b00, "stall_hold_busy");
        applyStimulus(mk(1, 13, 1, 0), nop, 2'b10, 0, 0, 0, 1, 2'b01, "ld13_issue");
        applyStimulus(mk(0, 14, 1, 2), mk(0, 15, 1, 2), 2'b11, 1, 1, 0, 1, 2'b00, "flush_using");
        checkOutput("flush_valid", 64'(o_EX_valid), 64'h0);
        applyStimulus(mk(0, 14, 13, 0), nop, 2'b10, 0, 0, 0, 1, 2'b01, "flush_clears_sb");

        applyStimulus(mk(1, 9, 1, 0), nop, 2'b10, 0, 0, 0, 1, 2'b01, "ld9_issue");
        applyStimulus(mk(0, 10, 9, 0), nop, 2'b10, 0, 0, 1, 1, 2'b00, "rst_using");
        checkOutput("rst_dual", 64'(o_dual_cnt), 64'd0);
        applyStimulus(mk(0, 10, 9, 0), nop, 2'b10, 0, 0, 0, 1, 2'b01, "post_rst_issue");

        for (int i = 0; i < 600; i++) begin
            PC_set ra;
            PC_set rb;
            ra = mk($urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
            rb = mk($urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
            applyStimulus(ra, rb, 2'($urandom_range(0, 3)),
                          ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 6),
                          ($urandom_range(0, 99) < 2), 1'b0, 2'b00, "");
        end

        run_compare = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
